muxn_lane_sel: RTL and testbench
================================

Name: muxn_lane_sel

Overview:
Parametrised N-channel, W-bit registered multiplexer for the vehicle level. It selects one lane pattern or sprite word from a packed bus. Selection comes either from a manual load strobe or from an automatic rotation that advances after a programmable dwell count of game ticks. It sits between the lane pattern generators and the vehicle renderer, and replaces chains of single-bit 2:1 muxes.

Parameters:
NUM_CH, 4, number of input channels (2..16)
DATA_W, 8, width of each channel in bits
SEL_W, 2, select width; must equal ceil(log2(NUM_CH))
DWELL, 16, TICK_IN pulses spent on each channel in auto mode (1..2^DWELL_W)
DWELL_W, 8, width of the dwell counter

Ports:
MUXNSEL_CLOCK_50  input  1  system clock; all state changes on the rising edge
MUXNSEL_RESET_InLow  input  1  asynchronous, active-low reset
MUXNSEL_MODE_IN  input  1  0 = manual, 1 = auto-rotate
MUXNSEL_SELECT_IN  input  SEL_W  channel index taken on a load
MUXNSEL_LOAD_IN  input  1  one-cycle strobe that loads SELECT_IN
MUXNSEL_TICK_IN  input  1  one-cycle game tick that advances the dwell counter (auto mode only)
MUXNSEL_HOLD_IN  input  1  freezes all internal state and outputs
MUXNSEL_DATA_IN  input  NUM_CH*DATA_W  packed channels; channel k at [k*DATA_W +: DATA_W]
MUXNSEL_DATA_OUT  output  DATA_W  registered selected channel
MUXNSEL_SEL_OUT  output  SEL_W  current selection register
MUXNSEL_VALID_OUT  output  1  DATA_OUT corresponds to SEL_OUT
MUXNSEL_WRAP_OUT  output  1  one-cycle pulse when auto rotation wraps from NUM_CH-1 to 0
MUXNSEL_ERR_OUT  output  1  one-cycle pulse when a load is rejected (SELECT_IN >= NUM_CH)

Behaviour:
- Reset (RESET_InLow = 0, asynchronous):
  - DATA_OUT=0, SEL_OUT=0, VALID_OUT=0, WRAP_OUT=0, ERR_OUT=0.
  - Dwell counter = 0; registered previous mode = 0.
  - Reset asserted mid-rotation or mid-load aborts immediately; nothing is retained.
- Data path, every edge with HOLD_IN=0:
  - DATA_OUT <= DATA_IN[SEL_OUT] using the pre-edge SEL_OUT.
  - Latency is 1 cycle from DATA_IN to DATA_OUT.
  - Latency is 2 cycles from an accepted load or advance to the new channel's data appearing on DATA_OUT.
- VALID_OUT, with HOLD_IN=0:
  - <= 0 on any edge where SEL_OUT changes value.
  - <= 1 otherwise.
  - First cycle after reset release: VALID_OUT=0. It rises after the first non-hold edge.
- Selection update priority per edge: HOLD > LOAD > TICK.
  - HOLD_IN=1: SEL_OUT, dwell counter, DATA_OUT and VALID_OUT keep their values. WRAP_OUT and ERR_OUT are 0. LOAD and TICK are dropped, not queued.
  - LOAD_IN=1, any mode:
    - If SELECT_IN < NUM_CH: SEL_OUT <= SELECT_IN and dwell counter <= 0.
    - Else: SEL_OUT is unchanged and ERR_OUT pulses for 1 cycle.
    - Loading the current value clears the dwell counter and keeps VALID_OUT=1.
  - TICK_IN=1, MODE_IN=1, no load:
    - If dwell counter == DWELL-1: counter <= 0 and SEL_OUT advances. At NUM_CH-1 it advances to 0 and WRAP_OUT pulses for 1 cycle; otherwise SEL_OUT+1.
    - Else: counter increments.
  - TICK_IN in manual mode is ignored and the counter is held.
- Mode changes:
  - The edge where the registered previous mode differs from MODE_IN clears the dwell counter. This applies in both directions.
  - A tick on that same edge is ignored.
  - A load on that same edge still applies.
- DWELL=1: every tick in auto mode advances SEL_OUT.
- NUM_CH a power of two: ERR_OUT can never assert.
- Outputs are glitch-free: all are registered, with no combinational path from input to output.

Test Plan:
- Reset release, NUM_CH=4, DATA_W=8, DATA_IN={8'h44,8'h33,8'h22,8'h11}, idle -> DATA_OUT=8'h11, SEL_OUT=0; VALID_OUT=0 in cycle 0, then 1 from the next edge.
- Manual mode, LOAD_IN with SELECT_IN=2 -> SEL_OUT=2 after 1 edge with VALID_OUT=0; DATA_OUT=8'h33 and VALID_OUT=1 after the 2nd edge.
- Auto mode, DWELL=3, TICK_IN every 5 cycles from SEL_OUT=3 -> after 3 ticks SEL_OUT=0 with a single WRAP_OUT pulse; 3 more ticks -> SEL_OUT=1 with no WRAP pulse.
- Auto mode, 2 ticks counted, then HOLD_IN for 10 cycles with 2 ticks and a load during hold -> SEL_OUT, DATA_OUT and counter unchanged; 1 tick after hold releases -> advance.
- NUM_CH=3, LOAD_IN with SELECT_IN=3 -> ERR_OUT pulses for 1 cycle, SEL_OUT unchanged; LOAD and TICK on the same edge -> load wins and the counter is cleared.
- Assert RESET_InLow asynchronously between clock edges during auto rotation -> all outputs 0 immediately; after release, rotation restarts from channel 0 with a full dwell.

Source files
------------

// File: rtl/muxn_lane_sel.sv
`default_nettype none
// ============================================================================
// Module  : muxn_lane_sel
// Brief   : N-channel registered lane/sprite word mux with manual load and
//           tick-driven auto rotation after a programmable dwell.
// Revision: 1.0 - initial release
// ============================================================================
module muxn_lane_sel #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int SEL_W   = 2,
    parameter int DWELL   = 16,
    parameter int DWELL_W = 8
) (
    input  logic                     MUXNSEL_CLOCK_50,
    input  logic                     MUXNSEL_RESET_InLow,
    input  logic                     MUXNSEL_MODE_IN,
    input  logic [SEL_W-1:0]         MUXNSEL_SELECT_IN,
    input  logic                     MUXNSEL_LOAD_IN,
    input  logic                     MUXNSEL_TICK_IN,
    input  logic                     MUXNSEL_HOLD_IN,
    input  logic [NUM_CH*DATA_W-1:0] MUXNSEL_DATA_IN,
    output logic [DATA_W-1:0]        MUXNSEL_DATA_OUT,
    output logic [SEL_W-1:0]         MUXNSEL_SEL_OUT,
    output logic                     MUXNSEL_VALID_OUT,
    output logic                     MUXNSEL_WRAP_OUT,
    output logic                     MUXNSEL_ERR_OUT
);

    localparam int                 NUM_SLOT   = 1 << SEL_W;
    localparam logic [SEL_W-1:0]   LAST_CH    = SEL_W'(NUM_CH - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

    logic [DATA_W-1:0]  slot [NUM_SLOT];
    logic               sel_ok;
    logic               mode_chg;

    logic [DATA_W-1:0]  data_q,  data_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [DWELL_W-1:0] cnt_q,   cnt_d;
    logic               valid_q, valid_d;
    logic               wrap_q,  wrap_d;
    logic               err_q,   err_d;
    logic               mode_prev_q, mode_prev_d;

    // Unused select codes read as zero so the mux index never leaves the array.
    generate
        for (genvar k = 0; k < NUM_SLOT; k++) begin : g_slot
            if (k < NUM_CH) begin : g_used
                assign slot[k] = MUXNSEL_DATA_IN[k*DATA_W +: DATA_W];
            end else begin : g_pad
                assign slot[k] = '0;
            end
        end
    endgenerate

    generate
        if (NUM_CH == NUM_SLOT) begin : g_sel_full
            assign sel_ok = 1'b1;
        end else begin : g_sel_part
            assign sel_ok = (MUXNSEL_SELECT_IN <= LAST_CH);
        end
    endgenerate

    assign mode_chg = (mode_prev_q != MUXNSEL_MODE_IN);

    always_comb begin
        data_d      = data_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        mode_prev_d = mode_prev_q;
        wrap_d      = 1'b0;
        err_d       = 1'b0;

        if (!MUXNSEL_HOLD_IN) begin
            mode_prev_d = MUXNSEL_MODE_IN;
            data_d      = slot[sel_q];

            if (mode_chg) begin
                cnt_d = '0;
            end

            // Load beats tick; a tick on a mode-change edge is discarded.
            if (MUXNSEL_LOAD_IN) begin
                if (sel_ok) begin
                    sel_d = MUXNSEL_SELECT_IN;
                    cnt_d = '0;
                end else begin
                    err_d = 1'b1;
                end
            end else if (MUXNSEL_TICK_IN && MUXNSEL_MODE_IN && !mode_chg) begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (sel_q == LAST_CH) begin
                        sel_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            valid_d = (sel_d == sel_q);
        end
    end

    always_ff @(posedge MUXNSEL_CLOCK_50 or negedge MUXNSEL_RESET_InLow) begin
        if (!MUXNSEL_RESET_InLow) begin
            data_q      <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
            mode_prev_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
            mode_prev_q <= mode_prev_d;
        end
    end

    assign MUXNSEL_DATA_OUT  = data_q;
    assign MUXNSEL_SEL_OUT   = sel_q;
    assign MUXNSEL_VALID_OUT = valid_q;
    assign MUXNSEL_WRAP_OUT  = wrap_q;
    assign MUXNSEL_ERR_OUT   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_muxn_lane_sel.sv
`default_nettype none
// ============================================================================
// Module  : tb_muxn_lane_sel
// Brief   : Directed self-checking bench for muxn_lane_sel (4- and 3-channel).
// Revision: 1.0 - initial release
// ============================================================================
module tb_muxn_lane_sel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode, load, tick, hold;
    logic [1:0]  sel_in;
    logic [31:0] a_data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    logic [23:0] b_data_in = {8'h33, 8'h22, 8'h11};

    logic [7:0]  a_data, b_data;
    logic [1:0]  a_sel, b_sel;
    logic        a_valid, a_wrap, a_err;
    logic        b_valid, b_wrap, b_err;

    int n_tests = 0;
    int n_fail  = 0;
    int a_wraps = 0;
    int b_wraps = 0;

    always #5 clk = ~clk;

    muxn_lane_sel #(.NUM_CH(4), .DATA_W(8), .SEL_W(2), .DWELL(3), .DWELL_W(8)) u_dut_a (
        .MUXNSEL_CLOCK_50    (clk),
        .MUXNSEL_RESET_InLow (rst_n),
        .MUXNSEL_MODE_IN     (mode),
        .MUXNSEL_SELECT_IN   (sel_in),
        .MUXNSEL_LOAD_IN     (load),
        .MUXNSEL_TICK_IN     (tick),
        .MUXNSEL_HOLD_IN     (hold),
        .MUXNSEL_DATA_IN     (a_data_in),
        .MUXNSEL_DATA_OUT    (a_data),
        .MUXNSEL_SEL_OUT     (a_sel),
        .MUXNSEL_VALID_OUT   (a_valid),
        .MUXNSEL_WRAP_OUT    (a_wrap),
        .MUXNSEL_ERR_OUT     (a_err)
    );

    muxn_lane_sel #(.NUM_CH(3), .DATA_W(8), .SEL_W(2), .DWELL(3), .DWELL_W(8)) u_dut_b (
        .MUXNSEL_CLOCK_50    (clk),
        .MUXNSEL_RESET_InLow (rst_n),
        .MUXNSEL_MODE_IN     (mode),
        .MUXNSEL_SELECT_IN   (sel_in),
        .MUXNSEL_LOAD_IN     (load),
        .MUXNSEL_TICK_IN     (tick),
        .MUXNSEL_HOLD_IN     (hold),
        .MUXNSEL_DATA_IN     (b_data_in),
        .MUXNSEL_DATA_OUT    (b_data),
        .MUXNSEL_SEL_OUT     (b_sel),
        .MUXNSEL_VALID_OUT   (b_valid),
        .MUXNSEL_WRAP_OUT    (b_wrap),
        .MUXNSEL_ERR_OUT     (b_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n edges; sample 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (a_wrap) a_wraps++;
            if (b_wrap) b_wraps++;
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(4);
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; load = 1'b0; tick = 1'b0; hold = 1'b0; sel_in = 2'd0;
        step(2);
        check("rst_data",  a_data,  0);
        check("rst_sel",   a_sel,   0);
        check("rst_valid", a_valid, 0);

        // Reset release
        rst_n = 1'b1;
        #2;
        check("rel_valid0", a_valid, 0);
        step(1);
        check("rel_data",   a_data,  8'h11);
        check("rel_sel",    a_sel,   0);
        check("rel_valid1", a_valid, 1);

        // Manual load of channel 2
        load = 1'b1; sel_in = 2'd2;
        step(1);
        load = 1'b0;
        check("ld_sel",    a_sel,   2);
        check("ld_valid0", a_valid, 0);
        check("ld_data0",  a_data,  8'h11);
        step(1);
        check("ld_data1",  a_data,  8'h33);
        check("ld_valid1", a_valid, 1);

        // Auto rotation from channel 3, dwell of 3 ticks
        load = 1'b1; sel_in = 2'd3;
        step(1);
        load = 1'b0;
        mode = 1'b1;
        step(1);
        a_wraps = 0;
        pulse_tick(); pulse_tick();
        check("auto_pre_sel", a_sel, 3);
        pulse_tick();
        check("auto_wrap_sel", a_sel, 0);
        check("auto_wrap_cnt", a_wraps, 1);
        check("auto_wrap_dat", a_data, 8'h11);
        pulse_tick(); pulse_tick(); pulse_tick();
        check("auto_adv_sel",  a_sel, 1);
        check("auto_nowrap",   a_wraps, 1);

        // Hold freezes state; ticks and load during hold are dropped
        pulse_tick(); pulse_tick();
        check("pre_hold_sel", a_sel, 1);
        check("pre_hold_dat", a_data, 8'h22);
        hold = 1'b1;
        step(2);
        tick = 1'b1; step(1); tick = 1'b0;
        step(2);
        tick = 1'b1; step(1); tick = 1'b0;
        load = 1'b1; sel_in = 2'd3; step(1); load = 1'b0;
        check("hold_err",  a_err, 0);
        step(3);
        check("hold_sel",   a_sel,   1);
        check("hold_dat",   a_data,  8'h22);
        check("hold_valid", a_valid, 1);
        hold = 1'b0;
        pulse_tick();
        check("post_hold_sel", a_sel,  2);
        check("post_hold_dat", a_data, 8'h33);

        // Asynchronous reset between edges during rotation
        pulse_tick();
        #3 rst_n = 1'b0;
        #1;
        check("arst_sel",   a_sel,   0);
        check("arst_data",  a_data,  0);
        check("arst_valid", a_valid, 0);
        check("arst_wrap",  a_wrap,  0);
        #2 rst_n = 1'b1;
        step(1);
        a_wraps = 0;
        pulse_tick(); pulse_tick();
        check("arst_dwell_sel", a_sel, 0);
        pulse_tick();
        check("arst_adv_sel",  a_sel,  1);
        check("arst_adv_dat",  a_data, 8'h22);

        // Three-channel instance: rejected load, load vs tick priority
        mode = 1'b0;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        load = 1'b1; sel_in = 2'd1; step(1); load = 1'b0;
        check("b_ld_sel", b_sel, 1);
        load = 1'b1; sel_in = 2'd3; step(1); load = 1'b0;
        check("b_err1",     b_err, 1);
        check("b_err_sel",  b_sel, 1);
        step(1);
        check("b_err0",     b_err, 0);
        check("a_no_err",   a_err, 0);
        mode = 1'b1;
        step(1);
        b_wraps = 0;
        pulse_tick(); pulse_tick();
        check("b_cnt2_sel", b_sel, 1);
        load = 1'b1; tick = 1'b1; sel_in = 2'd2;
        step(1);
        load = 1'b0; tick = 1'b0;
        step(4);
        check("b_ldtick_sel", b_sel, 2);
        pulse_tick(); pulse_tick();
        check("b_clr_sel", b_sel, 2);
        pulse_tick();
        check("b_wrap_sel", b_sel, 0);
        check("b_wrap_cnt", b_wraps, 1);
        check("b_wrap_dat", b_data, 8'h11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
